// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - sequential shift-add multiplier with start/busy/done handshake
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WIDTH-1:0]     a_bi,
    input  logic [WIDTH-1:0]     b_bi,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   y_bo,
    output logic [WIDTH-1:0]     y_sat_bo
);

    // Counter carries one spare bit so it never wraps before the final compare.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t              state_q, state_d;

    // The multiplicand is pre-shifted and the multiplier consumed LSB first,
    // which is equivalent to adding (a << ctr) when b[ctr] is set.
    logic [2*WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]    b_sh_q, b_sh_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]       ctr_q, ctr_d;
    logic [2*WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]    y_sat_q, y_sat_d;
    logic                done_q, done_d;

    logic [2*WIDTH-1:0]  partial;
    logic [2*WIDTH-1:0]  acc_sum;
    logic                last_iter;
    logic                start_accept;

    assign start_accept = (state_q == IDLE) && start_i;
    assign last_iter    = (state_q == WORK) && (ctr_q == LAST_ITER);
    assign partial      = b_sh_q[0] ? a_sh_q : '0;
    assign acc_sum      = acc_q + partial;

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: the completion edge returns to IDLE without sampling start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = WORK;
                end
            end
            WORK: begin
                if (ctr_q == LAST_ITER) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: busy follows the state, results come straight from registers.
    always_comb begin
        busy_o   = (state_q == WORK);
        done_o   = done_q;
        y_bo     = y_q;
        y_sat_bo = y_sat_q;
    end

    // Datapath next-state: latch on accept, shift-add while working, publish on the last iteration.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        ctr_d   = ctr_q;
        y_d     = y_q;
        y_sat_d = y_sat_q;
        done_d  = 1'b0;

        if (start_accept) begin
            a_sh_d = {{WIDTH{1'b0}}, a_bi};
            b_sh_d = b_bi;
            acc_d  = '0;
            ctr_d  = '0;
        end else if (state_q == WORK) begin
            acc_d  = acc_sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            ctr_d  = ctr_q + CW'(1);
            if (last_iter) begin
                y_d     = acc_sum;
                y_sat_d = (|acc_sum[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}}
                                                       : acc_sum[WIDTH-1:0];
                done_d  = 1'b1;
            end
        end
    end

    // Datapath registers; reset clears everything so an aborted run leaves no trace.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            ctr_q   <= '0;
            y_q     <= '0;
            y_sat_q <= '0;
            done_q  <= 1'b0;
        end else begin
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            ctr_q   <= ctr_d;
            y_q     <= y_d;
            y_sat_q <= y_sat_d;
            done_q  <= done_d;
        end
    end

endmodule
